// File: rtl/adder_arbiter.sv
// Four-way arbiter sharing one external registered adder; one transaction in flight.
// Define ADDER_ARB_FIXED_PRIO_EN for fixed priority (req[0] highest) instead of round-robin.
module adder_arbiter #(
  parameter int BIT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             req,
  input  logic [4*BIT_WIDTH-1:0] op_a,
  input  logic [4*BIT_WIDTH-1:0] op_b,
  output logic [3:0]             gnt,
  output logic [BIT_WIDTH-1:0]   add_a,
  output logic [BIT_WIDTH-1:0]   add_b,
  output logic                   add_rst,
  input  logic [BIT_WIDTH-1:0]   add_sum,
  output logic [BIT_WIDTH-1:0]   result,
  output logic [1:0]             result_id,
  output logic                   result_valid,
  input  logic                   result_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t               r_state;
  logic [3:0]           r_gnt;
  logic [BIT_WIDTH-1:0] r_add_a;
  logic [BIT_WIDTH-1:0] r_add_b;
  logic [BIT_WIDTH-1:0] r_result;
  logic [1:0]           r_id;
  logic                 r_valid;
  logic [1:0]           w_win;

`ifdef ADDER_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest active index is written last.
  always_comb begin
    w_win = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) w_win = 2'(i);
    end
  end
`else
  logic [1:0] r_ptr;
  logic [1:0] w_idx;

  // Descending offset scan: the requester closest to r_ptr wins.
  always_comb begin
    w_win = 2'd0;
    w_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      w_idx = r_ptr + 2'(i);
      if (req[w_idx]) w_win = w_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= 2'd0;
    end else if (r_state == IDLE && |req) begin
      r_ptr <= w_win + 2'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_add_a  <= '0;
      r_add_b  <= '0;
      r_result <= '0;
      r_id     <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_gnt <= '0;
      unique case (r_state)
        IDLE: begin
          if (|req) begin
            r_add_a <= op_a[int'(w_win)*BIT_WIDTH +: BIT_WIDTH];
            r_add_b <= op_b[int'(w_win)*BIT_WIDTH +: BIT_WIDTH];
            r_id    <= w_win;
            r_gnt   <= 4'b0001 << w_win;
            r_state <= ISSUE;
          end
        end
        ISSUE: r_state <= CAPT;
        CAPT: begin
          r_result <= add_sum;
          r_valid  <= 1'b1;
          r_state  <= RESP;
        end
        RESP: begin
          if (result_ready) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt          = r_gnt;
  assign add_a        = r_add_a;
  assign add_b        = r_add_b;
  assign add_rst      = ~reset;
  assign result       = r_result;
  assign result_id    = r_id;
  assign result_valid = r_valid;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a behavioural registered adder.
// Expected values are hand-computed; checks sample on the falling edge.
module tb_adder_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  gnt;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic        add_rst;
  logic [7:0]  add_sum;
  logic [7:0]  result;
  logic [1:0]  result_id;
  logic        result_valid;
  logic        result_ready;

  int total;
  int passed;

  adder_arbiter #(.BIT_WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .op_a         (op_a),
    .op_b         (op_b),
    .gnt          (gnt),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_rst      (add_rst),
    .add_sum      (add_sum),
    .result       (result),
    .result_id    (result_id),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared adder: one-cycle registered sum, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (add_rst) add_sum <= 8'd0;
    else         add_sum <= add_a + add_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic nedge();
    @(negedge clk);
    #1;
  endtask

  // Issue one request from IDLE with ready=1 and follow it to completion.
  task automatic txn(input string tag, input logic [3:0] r,
                     input logic [3:0] eg, input logic [7:0] es,
                     input logic [1:0] eid);
    req = r;
    nedge();
    chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
    req = 4'b0000;
    nedge();
    chk({tag, "_gnt0"}, 32'(gnt), 32'd0);
    nedge();
    chk({tag, "_vld"}, 32'(result_valid), 32'd1);
    chk({tag, "_res"}, 32'(result), 32'(es));
    chk({tag, "_id"}, 32'(result_id), 32'(eid));
    nedge();
    chk({tag, "_vld0"}, 32'(result_valid), 32'd0);
  endtask

  logic [3:0] rr_g [5];
  logic [7:0] rr_s [5];
  logic [1:0] rr_i [5];

  initial begin
    total = 0;
    passed = 0;
    reset = 1'b0;
    req = 4'b0;
    op_a = 32'h0;
    op_b = 32'h0;
    result_ready = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_adda", 32'(add_a), 32'd0);
    chk("rst_vld", 32'(result_valid), 32'd0);
    chk("rst_res", 32'(result), 32'd0);
    chk("rst_addrst", 32'(add_rst), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_addrst", 32'(add_rst), 32'd0);

    // Single add 3+4 from slot 0, result held while ready is low.
    op_a = 32'h0000_0003;
    op_b = 32'h0000_0004;
    req = 4'b0001;
    nedge();
    chk("s_gnt", 32'(gnt), 32'h1);
    chk("s_adda", 32'(add_a), 32'd3);
    chk("s_addb", 32'(add_b), 32'd4);
    req = 4'b0000;
    nedge();
    chk("s_gnt0", 32'(gnt), 32'd0);
    chk("s_vld_early", 32'(result_valid), 32'd0);
    nedge();
    chk("s_vld", 32'(result_valid), 32'd1);
    chk("s_res", 32'(result), 32'd7);
    chk("s_id", 32'(result_id), 32'd0);
    result_ready = 1'b1;
    nedge();
    chk("s_vld0", 32'(result_valid), 32'd0);

    // Carry discarded: F0+20 from slot 2; ready high when valid rises.
    op_a = 32'h00F0_0000;
    op_b = 32'h0020_0000;
    txn("wrap", 4'b0100, 4'b0100, 8'h10, 2'd2);

    // Pointer: grant 3, then 1001 goes to 0, then 1001 goes to 3.
    op_a = 32'h5000_0050;
    op_b = 32'h0500_0005;
    txn("p3", 4'b1000, 4'b1000, 8'h55, 2'd3);
    txn("p0", 4'b1001, 4'b0001, 8'h55, 2'd0);
`ifdef ADDER_ARB_FIXED_PRIO_EN
    txn("p1", 4'b1001, 4'b0001, 8'h55, 2'd0);
`else
    txn("p1", 4'b1001, 4'b1000, 8'h55, 2'd3);
`endif
    // Re-park the pointer at 0 for the rotation test.
    txn("p2", 4'b1000, 4'b1000, 8'h55, 2'd3);

    // All four requesting, ready held high: grants every 4 cycles.
    op_a = 32'h4030_2010;
    op_b = 32'h0403_0201;
`ifdef ADDER_ARB_FIXED_PRIO_EN
    rr_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    rr_s = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11};
    rr_i = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
    rr_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_s = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    rr_i = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      nedge();
      chk($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(rr_g[k]));
      nedge();
      chk($sformatf("rr%0d_gnt0", k), 32'(gnt), 32'd0);
      nedge();
      chk($sformatf("rr%0d_res", k), 32'(result), 32'(rr_s[k]));
      chk($sformatf("rr%0d_id", k), 32'(result_id), 32'(rr_i[k]));
      nedge();
      chk($sformatf("rr%0d_vld0", k), 32'(result_valid), 32'd0);
    end
    req = 4'b0000;

    // Backpressure on slot 1 while slot 2 keeps requesting.
    result_ready = 1'b0;
    req = 4'b0010;
    nedge();
    chk("bp_gnt", 32'(gnt), 32'b0010);
    req = 4'b0100;
    nedge();
    nedge();
    chk("bp_vld", 32'(result_valid), 32'd1);
    for (int k = 0; k < 10; k++) begin
      nedge();
      chk($sformatf("bp%0d_hold", k),
          {20'd0, gnt, result, 1'b0, result_valid, result_id},
          {20'd0, 4'b0000, 8'h22, 1'b0, 1'b1, 2'd1});
    end
    result_ready = 1'b1;
    nedge();
    chk("bp_vld0", 32'(result_valid), 32'd0);
    chk("bp_nognt", 32'(gnt), 32'd0);
    nedge();
    chk("bp_next_gnt", 32'(gnt), 32'b0100);
    req = 4'b0000;
    nedge();
    nedge();
    chk("bp_next_res", 32'(result), 32'h33);
    chk("bp_next_id", 32'(result_id), 32'd2);
    nedge();

    // Reset while the transaction sits in CAPT.
    result_ready = 1'b0;
    req = 4'b0001;
    nedge();
    chk("mr_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    nedge();
    reset = 1'b0;
    #1;
    chk("mr_outs",
        {gnt, add_a, add_b, result, result_id, result_valid, add_rst},
        {4'd0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b1});
    nedge();
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      nedge();
      chk($sformatf("mr%0d_quiet", k), {27'd0, gnt, result_valid},
          32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
